alu32_op_sequencer: RTL and testbench

//  Upstream issue stage for the gate-level ALU32 datapath. Buffers ALU operations (3-bit opcode + two
//  32-bit operands) in a small FIFO via valid/ready. Issues one at a time: opcode bits go to the 3-to-8
//  op decoder, operands go to the ALU. After a fixed ALU latency it captures the result and presents it

---
 rtl/alu32_pkg.sv | 12 +
 rtl/alu32_op_fifo.sv | 59 +++++
 rtl/alu32_op_sequencer.sv | 136 +++++++++++++
 tb/tb_alu32_op_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu32_pkg.sv
// Shared widths and FSM encodings for the ALU32 op sequencer.
package alu32_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu32_op_fifo.sv
// Synchronous FIFO holding pending ALU ops; count/full/empty are registered.
module alu32_op_fifo #(
    parameter int unsigned WIDTH = 67,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_nxt;

    // A push is refused while full even when a pop frees a slot on the same edge.
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign count_nxt = count + CW'(do_push) - CW'(do_pop);
    assign rd_data   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/alu32_op_sequencer.sv
// Issue stage for the ALU32 datapath: queues ops, issues one at a time,
// waits a fixed ALU latency, then presents the captured result downstream.
module alu32_op_sequencer
    import alu32_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              dec_a0,
    output logic              dec_a1,
    output logic              dec_a2,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [DATA_W-1:0] out_result,
    output logic              busy
);

    localparam int unsigned ENT_W = OP_W + 2 * DATA_W;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned LW    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_e            state;
    logic [LW-1:0]     lat_cnt;
    logic [OP_W-1:0]   issue_op;
    logic [ENT_W-1:0]  fifo_rd;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push_c;
    logic              pop_c;
    logic              to_idle_c;
    logic [CW-1:0]     cnt_after_c;
    logic              busy_nxt_c;

    alu32_op_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_c),
        .pop     (pop_c),
        .wr_data ({in_op, in_a, in_b}),
        .rd_data (fifo_rd),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign in_ready = ~fifo_full;
    assign dec_a0   = issue_op[0];
    assign dec_a1   = issue_op[1];
    assign dec_a2   = issue_op[2];

    // Pop decision and the post-edge occupancy used to register busy.
    always_comb begin
        push_c    = in_valid & ~fifo_full;
        pop_c     = 1'b0;
        to_idle_c = 1'b0;
        case (state)
            ST_IDLE: begin
                pop_c     = ~fifo_empty;
                to_idle_c = fifo_empty;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    pop_c     = ~fifo_empty;
                    to_idle_c = fifo_empty;
                end
            end
            default: begin
            end
        endcase
        cnt_after_c = fifo_count + CW'(push_c) - CW'(pop_c);
        busy_nxt_c  = ~to_idle_c | (cnt_after_c != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            lat_cnt    <= '0;
            issue_op   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            out_op     <= '0;
            out_result <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            busy <= busy_nxt_c;
            if (pop_c) begin
                {issue_op, alu_a, alu_b} <= fifo_rd;
                lat_cnt                  <= LW'(ALU_LAT - 1);
            end
            case (state)
                ST_IDLE: begin
                    if (pop_c) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - LW'(1);
                    end else begin
                        out_result <= alu_result;
                        out_op     <= issue_op;
                        out_valid  <= 1'b1;
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= pop_c ? ST_WAIT : ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu32_op_sequencer.sv
// Directed, table-driven bench for alu32_op_sequencer with a combinational ALU model.
module tb_alu32_op_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        dec_a0;
    logic        dec_a1;
    logic        dec_a2;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_op;
    logic [31:0] out_result;
    logic        busy;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    vec_t vec [8];
    int   checks;
    int   errors;

    alu32_op_sequencer #(
        .DATA_W  (32),
        .DEPTH   (4),
        .ALU_LAT (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .dec_a0     (dec_a0),
        .dec_a1     (dec_a1),
        .dec_a2     (dec_a2),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_result (out_result),
        .busy       (busy)
    );

    function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[4:0];
            3'd6:    return a >> b[4:0];
            default: return ~a;
        endcase
    endfunction

    assign alu_result = alu_model({dec_a2, dec_a1, dec_a0}, alu_a, alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Drives pushes vec[pf..pt-1] and checks deliveries vec[ef..et-1] in order.
    task automatic run(input int pf, input int pt, input int ef, input int et,
                       input int budget, input bit gap);
        int pi;
        int ei;
        int n;
        int last;
        bit acc;
        bit del;
        pi   = pf;
        ei   = ef;
        n    = 0;
        last = -1;
        while ((pi < pt || ei < et) && n < budget) begin
            if (pi < pt) begin
                in_valid = 1'b1;
                in_op    = vec[pi % 8].op;
                in_a     = vec[pi % 8].a;
                in_b     = vec[pi % 8].b;
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
            del = out_valid && out_ready;
            if (del) begin
                if (ei < et) begin
                    chk($sformatf("result%0d", ei), out_result, vec[ei % 8].res);
                    chk($sformatf("out_op%0d", ei), {29'd0, out_op}, {29'd0, vec[ei % 8].op});
                    if (gap && last >= 0) begin
                        chk($sformatf("gap%0d", ei), 32'(n - last), 32'd2);
                    end
                    last = n;
                    ei++;
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL extra_result: got 0x%08h expected no delivery", out_result);
                end
            end
            step();
            n++;
            if (acc) begin
                pi++;
            end
        end
        in_valid = 1'b0;
        if (pi < pt || ei < et) begin
            checks++;
            errors++;
            $display("FAIL timeout: pushed %0d of %0d, delivered %0d of %0d", pi, pt, ei, et);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vec[0] = '{3'd0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
        vec[1] = '{3'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        vec[2] = '{3'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00};
        vec[3] = '{3'd3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F};
        vec[4] = '{3'd4, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555};
        vec[5] = '{3'd5, 32'h0000_00F0, 32'h0000_000F, 32'h0078_0000};
        vec[6] = '{3'd6, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
        vec[7] = '{3'd7, 32'h1234_5678, 32'h0000_0000, 32'hEDCB_A987};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        out_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_dec", {29'd0, dec_a2, dec_a1, dec_a0}, 32'd0);

        // Single op latency
        in_valid = 1'b1;
        in_op    = vec[5].op;
        in_a     = vec[5].a;
        in_b     = vec[5].b;
        step();
        in_valid = 1'b0;
        step();
        chk("t1_dec", {29'd0, dec_a2, dec_a1, dec_a0}, 32'd5);
        chk("t1_alu_a", alu_a, 32'h0000_00F0);
        chk("t1_alu_b", alu_b, 32'h0000_000F);
        chk("t1_early_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_result", out_result, 32'h0078_0000);
        chk("t1_op", {29'd0, out_op}, 32'd5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_drop_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);

        // Fill with the consumer stalled, then drain
        run(0, 5, 0, 0, 30, 1'b0);
        chk("t2_full_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_op    = vec[5].op;
        in_a     = vec[5].a;
        in_b     = vec[5].b;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("t2_stall_ready%0d", i), {31'd0, in_ready}, 32'd0);
            chk($sformatf("t2_stall_res%0d", i), out_result, vec[0].res);
        end
        chk("t2_stall_op", {29'd0, out_op}, 32'd0);
        chk("t2_stall_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        run(5, 6, 0, 6, 40, 1'b0);
        out_ready = 1'b0;
        chk("t2_busy_end", {31'd0, busy}, 32'd0);

        // Streaming with pointer wrap, one result every two cycles
        out_ready = 1'b1;
        run(0, 8, 0, 8, 60, 1'b1);
        out_ready = 1'b0;
        chk("t3_busy_end", {31'd0, busy}, 32'd0);

        // Push+pop at count 2, then push refused while full
        run(0, 3, 0, 0, 20, 1'b0);
        chk("t4_count2", 32'(dut.u_fifo.count), 32'd2);
        chk("t4_hold_res0", out_result, vec[0].res);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = vec[3].op;
        in_a      = vec[3].a;
        in_b      = vec[3].b;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t4_pushpop_count", 32'(dut.u_fifo.count), 32'd2);
        run(4, 6, 0, 0, 20, 1'b0);
        chk("t4_full_ready", {31'd0, in_ready}, 32'd0);
        chk("t4_count4", 32'(dut.u_fifo.count), 32'd4);
        chk("t4_hold_res1", out_result, vec[1].res);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = vec[6].op;
        in_a      = vec[6].a;
        in_b      = vec[6].b;
        step();
        in_valid = 1'b0;
        chk("t4_refused_count", 32'(dut.u_fifo.count), 32'd3);
        run(6, 6, 2, 6, 40, 1'b0);
        out_ready = 1'b0;
        chk("t4_busy_end", {31'd0, busy}, 32'd0);

        // Reset mid-WAIT with three ops queued
        run(0, 5, 0, 0, 30, 1'b0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t5_pre_count", 32'(dut.u_fifo.count), 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_ready", {31'd0, in_ready}, 32'd1);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_dec", {29'd0, dec_a2, dec_a1, dec_a0}, 32'd0);
        chk("t5_alu_a", alu_a, 32'd0);
        out_ready = 1'b1;
        run(6, 7, 6, 7, 20, 1'b0);
        out_ready = 1'b0;
        chk("t5_busy_end", {31'd0, busy}, 32'd0);

        // Long backpressure in HOLD
        run(2, 3, 0, 0, 10, 1'b0);
        step();
        step();
        chk("t6_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("t6_res%0d", i), out_result, vec[2].res);
            chk($sformatf("t6_op%0d", i), {29'd0, out_op}, 32'd2);
            chk($sformatf("t6_dec%0d", i), {29'd0, dec_a2, dec_a1, dec_a0}, 32'd2);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t6_release_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_release_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
